truth_table_sweeper: RTL and testbench

- Stage directly upstream of a 3-input combinational function block (inputs a, b, c; output y).
- Replaces a hand-written stimulus list with synthesisable sequencing: on start it drives all 8 input combinations in ascending order, holds each for DWELL cycles and samples y at the end of each hold.
- Assembles the 8 samples into a truth-table word and compares it against a caller-supplied expected word.
- Used for on-board self-check of small DDCO combinational blocks.

---
 rtl/truth_table_sweeper.sv | 106 ++++++++++
 tb/tb_truth_table_sweeper.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps {a,b,c} through all 8 combinations, holds each for DWELL cycles and
// samples y at the end of each hold into a truth table checked against an expected word.
module truth_table_sweeper #(
  parameter int DWELL = 4  // legal 1..255; the dwell counter is 8 bits wide
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_expected,
  input  logic       i_y,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic [7:0] o_tt,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_match
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     r_state, w_next;
  logic [2:0] r_idx;
  logic [7:0] r_cnt;
  logic [7:0] r_tt;
  logic [7:0] r_exp;
  logic       r_match;

  logic       w_accept, w_sample, w_last;
  logic [7:0] w_tt_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_sample = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next   = S_DRIVE;
          w_accept = 1'b1;
        end
      end
      S_DRIVE: begin
        if (r_cnt == LAST) begin
          w_sample = 1'b1;
          if (r_idx == 3'd7) begin
            w_last = 1'b1;
            w_next = S_DONE;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Final table including the bit sampled this edge, so match is ready with done.
  always_comb begin
    w_tt_next        = r_tt;
    w_tt_next[r_idx] = i_y;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx   <= 3'd0;
      r_cnt   <= 8'd0;
      r_tt    <= 8'd0;
      r_exp   <= 8'd0;
      r_match <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= 3'd0;
      r_cnt   <= 8'd0;
      r_tt    <= 8'd0;
      r_exp   <= i_expected;
      r_match <= 1'b0;
    end else if (w_sample) begin
      r_tt <= w_tt_next;
      if (w_last) begin
        r_match <= (w_tt_next == r_exp);
      end else begin
        r_idx <= r_idx + 3'd1;
        r_cnt <= 8'd0;
      end
    end else if (r_state == S_DRIVE) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // idx is itself the registered stimulus; it parks at 7 after the sweep.
  assign o_a     = r_idx[2];
  assign o_b     = r_idx[1];
  assign o_c     = r_idx[0];
  assign o_tt    = r_tt;
  assign o_busy  = (r_state == S_DRIVE);
  assign o_done  = (r_state == S_DONE);
  assign o_match = r_match;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Two sweepers (DWELL=4 and DWELL=1) driving table-defined functions; a cycle model
// checks handshake/stimulus timing and a scoreboard checks tt/match at each done.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, start, y, oa, ob, oc, busy, done, match;
  logic [1:0][7:0] expected, func, tt;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] tt;
    logic       mt;
  } exp_t;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h want %0h @%0t", nm, d, act, exp, $time);
    end
  endtask

  // Functions under test are plain lookup tables indexed by {a,b,c}.
  assign y[0] = func[0][{oa[0], ob[0], oc[0]}];
  assign y[1] = func[1][{oa[1], ob[1], oc[1]}];

  truth_table_sweeper #(.DWELL(4)) u_d4 (
    .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .i_expected(expected[0]), .i_y(y[0]),
    .o_a(oa[0]), .o_b(ob[0]), .o_c(oc[0]), .o_tt(tt[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_match(match[0])
  );

  truth_table_sweeper #(.DWELL(1)) u_d1 (
    .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .i_expected(expected[1]), .i_y(y[1]),
    .o_a(oa[1]), .o_b(ob[1]), .o_c(oc[1]), .o_tt(tt[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_match(match[1])
  );

  for (genvar g = 0; g < 2; g++) begin : m
    localparam int D = (g == 0) ? 4 : 1;
    exp_t       sb[$];
    int         cy = 0;
    int         e0 = 0;
    bit         act = 0;
    bit         armed = 0;
    logic [2:0] abc_h = 3'd0;
    logic [7:0] tt_h = 8'd0;
    logic       mt_h = 1'b0;

    // Reference: a sweep accepted at edge e0 occupies cycles e0..e0+8D (last is done).
    always @(posedge clk) begin
      cy++;
      if (rst[g]) begin
        armed = 1;
        act   = 0;
        sb.delete();
        abc_h = 3'd0;
        tt_h  = 8'd0;
        mt_h  = 1'b0;
      end else if (!act) begin
        if (start[g]) begin
          act = 1;
          e0  = cy;
          sb.push_back('{func[g], (func[g] == expected[g])});
          tt_h = 8'd0;
          mt_h = 1'b0;
        end
      end else if (cy == e0 + 8 * D + 1) begin
        act = 0;
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        if (done[g]) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", g, 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("tt", g, tt[g], e.tt);
            chk("match", g, match[g], e.mt);
            tt_h = e.tt;
            mt_h = e.mt;
          end
        end
        if (act && cy < e0 + 8 * D) begin
          chk("busy", g, busy[g], 1);
          chk("done", g, done[g], 0);
          chk("abc", g, {oa[g], ob[g], oc[g]}, 32'((cy - e0) / D));
          chk("match_clr", g, match[g], 0);
        end else if (act) begin
          abc_h = 3'd7;
          chk("busy", g, busy[g], 0);
          chk("done", g, done[g], 1);
          chk("abc", g, {oa[g], ob[g], oc[g]}, 7);
        end else begin
          chk("busy", g, busy[g], 0);
          chk("done", g, done[g], 0);
          chk("abc_hold", g, {oa[g], ob[g], oc[g]}, abc_h);
          chk("tt_hold", g, tt[g], tt_h);
          chk("match_hold", g, match[g], mt_h);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 2'b11;
    start    = 2'b00;
    expected = '0;
    func[0]  = 8'hE8;  // majority
    func[1]  = 8'h96;  // xor3
    tick(2);
    rst = 2'b00;
    tick(10);

    // Majority, matching then non-matching expected, then rerun matching
    expected[0] = 8'hE8; start[0] = 1'b1; tick(1); start[0] = 1'b0; tick(40);
    expected[0] = 8'hE9; start[0] = 1'b1; tick(1); start[0] = 1'b0; tick(40);
    expected[0] = 8'hE8; start[0] = 1'b1; tick(1); start[0] = 1'b0; tick(40);

    // DWELL=1 xor3 with start held: back-to-back sweeps with one idle cycle
    expected[1] = 8'h96; start[1] = 1'b1; tick(40); start[1] = 1'b0; tick(5);

    // Reset landing at edge E0+13
    expected[0] = 8'hE8; start[0] = 1'b1; tick(1); start[0] = 1'b0;
    tick(12); rst[0] = 1'b1; tick(1); rst[0] = 1'b0; tick(40);

    // Noise on start/expected while busy
    expected[0] = 8'h5A; start[0] = 1'b1; tick(1);
    for (int i = 0; i < 32; i++) begin
      start[0]    = 1'($urandom);
      expected[0] = 8'($urandom);
      tick(1);
    end
    start[0] = 1'b0;
    tick(80);

    // Random functions and expectations on both sweepers
    for (int i = 0; i < 30; i++) begin
      for (int g = 0; g < 2; g++) begin
        func[g]     = 8'($urandom);
        expected[g] = ($urandom_range(0, 1) == 1) ? func[g] : 8'($urandom);
      end
      start = 2'b11; tick(1); start = 2'b00; tick(36);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
